// File: rtl/rv_pkg.sv
// Shared RV32 decode constants and the shifter type codes used by the
// execute stage and by the decoder's legality checks.
package rv_pkg;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_BRANCH = 7'b1100011
    } opcode_e;

    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10
    } shift_type_e;

    // Only R-type, stores and branches read rs2; I-type reuses those bits as imm.
    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/shift_decode.sv
// Combinational decode of an RV32 instruction into barrel-shifter controls.
// Non-shift instructions yield all-zero outputs so the type code is never 11.
module shift_decode
    import rv_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    output logic       o_shift_en,
    output logic [1:0] o_shift_type,
    output logic       o_shamt_imm
);

    logic w_is_alu;
    logic w_is_imm;

    assign w_is_alu = (i_opcode == OPC_OP) || (i_opcode == OPC_OP_IMM);
    assign w_is_imm = (i_opcode == OPC_OP_IMM);

    always_comb begin
        o_shift_en   = 1'b0;
        o_shift_type = SHIFT_SLL;
        o_shamt_imm  = 1'b0;
        if (w_is_alu && (i_funct3 == F3_SLL)) begin
            o_shift_en   = 1'b1;
            o_shift_type = SHIFT_SLL;
            o_shamt_imm  = w_is_imm;
        end else if (w_is_alu && (i_funct3 == F3_SRL_SRA)) begin
            o_shift_en   = 1'b1;
            o_shift_type = i_funct7_5 ? SHIFT_SRA : SHIFT_SRL;
            o_shamt_imm  = w_is_imm;
        end
    end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: latches decoded operands/control, registers the
// shift decode, and raises a combinational load-use hazard against EX.
module id_ex_reg
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [6:0]      id_opcode,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7_5,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_mem_to_reg,
    input  logic            id_branch,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [6:0]      ex_opcode,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7_5,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_mem_to_reg,
    output logic            ex_branch,
    output logic            ex_shift_en,
    output logic [1:0]      ex_shift_type,
    output logic            ex_shamt_imm,
    output logic            load_use_hazard
);

    // Control contract: stall freezes EX, flush/rst load a bubble, and the
    // hazard is raised ungated so the hazard unit can hold ID/PC while EX drains.
    logic            r_valid, r_funct7_5;
    logic [XLEN-1:0] r_pc, r_rs1_data, r_rs2_data, r_imm;
    logic [4:0]      r_rs1, r_rs2, r_rd;
    logic [6:0]      r_opcode;
    logic [2:0]      r_funct3;
    logic            r_reg_write, r_mem_read, r_mem_write, r_mem_to_reg, r_branch;
    logic            r_shift_en, r_shamt_imm;
    logic [1:0]      r_shift_type;

    logic            w_shift_en, w_shamt_imm;
    logic [1:0]      w_shift_type;
    logic            w_rd_match;
    logic            w_hazard;
    logic            w_bubble;
    logic            w_load;

    shift_decode u_shift_decode (
        .i_opcode     (id_opcode),
        .i_funct3     (id_funct3),
        .i_funct7_5   (id_funct7_5),
        .o_shift_en   (w_shift_en),
        .o_shift_type (w_shift_type),
        .o_shamt_imm  (w_shamt_imm)
    );

    assign w_rd_match = (r_rd == id_rs1) || (uses_rs2(id_opcode) && (r_rd == id_rs2));
    assign w_hazard   = r_valid && r_mem_read && (r_rd != 5'd0) && id_valid && w_rd_match;

    assign w_bubble = rst || flush || (!stall && w_hazard);
    assign w_load   = !stall && !w_hazard;

    always_ff @(posedge clk) begin
        if (w_bubble) begin
            r_valid      <= 1'b0;
            r_pc         <= '0;
            r_rs1_data   <= '0;
            r_rs2_data   <= '0;
            r_imm        <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_rd         <= '0;
            r_opcode     <= '0;
            r_funct3     <= '0;
            r_funct7_5   <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_branch     <= 1'b0;
            r_shift_en   <= 1'b0;
            r_shift_type <= SHIFT_SLL;
            r_shamt_imm  <= 1'b0;
        end else if (w_load) begin
            r_valid      <= id_valid;
            r_pc         <= id_pc;
            r_rs1_data   <= id_rs1_data;
            r_rs2_data   <= id_rs2_data;
            r_imm        <= id_imm;
            r_rs1        <= id_rs1;
            r_rs2        <= id_rs2;
            r_rd         <= id_rd;
            r_opcode     <= id_opcode;
            r_funct3     <= id_funct3;
            r_funct7_5   <= id_funct7_5;
            r_reg_write  <= id_reg_write;
            r_mem_read   <= id_mem_read;
            r_mem_write  <= id_mem_write;
            r_mem_to_reg <= id_mem_to_reg;
            r_branch     <= id_branch;
            r_shift_en   <= w_shift_en;
            r_shift_type <= w_shift_type;
            r_shamt_imm  <= w_shamt_imm;
        end
    end

    assign ex_valid        = r_valid;
    assign ex_pc           = r_pc;
    assign ex_rs1_data     = r_rs1_data;
    assign ex_rs2_data     = r_rs2_data;
    assign ex_imm          = r_imm;
    assign ex_rs1          = r_rs1;
    assign ex_rs2          = r_rs2;
    assign ex_rd           = r_rd;
    assign ex_opcode       = r_opcode;
    assign ex_funct3       = r_funct3;
    assign ex_funct7_5     = r_funct7_5;
    assign ex_reg_write    = r_reg_write;
    assign ex_mem_read     = r_mem_read;
    assign ex_mem_write    = r_mem_write;
    assign ex_mem_to_reg   = r_mem_to_reg;
    assign ex_branch       = r_branch;
    assign ex_shift_en     = r_shift_en;
    assign ex_shift_type   = r_shift_type;
    assign ex_shamt_imm    = r_shamt_imm;
    assign load_use_hazard = w_hazard;

endmodule
